// File: rtl/control_cmd_dispatch_if.sv
// Command-path bundle: byte stream in, per-handler strobes/resets out, handler RAM ports in,
// shared RAM port and status out. The framebuffer address type lives alongside it.
package types;
  typedef logic [15:0] fb_addr_t;
endpackage

interface control_cmd_dispatch_if #(
  parameter int NUM_SUB = 4,
  parameter int ADDR_W  = $bits(types::fb_addr_t)
);
  logic                      enable;
  logic [7:0]                data_in;
  logic [NUM_SUB-1:0]        sub_enable;
  logic [NUM_SUB-1:0]        sub_reset;
  logic [NUM_SUB-1:0]        sub_done;
  logic [NUM_SUB*ADDR_W-1:0] sub_addr;
  logic [NUM_SUB*8-1:0]      sub_data;
  logic [NUM_SUB-1:0]        sub_we;
  logic [NUM_SUB-1:0]        sub_as;
  logic [ADDR_W-1:0]         ram_addr;
  logic [7:0]                ram_data_out;
  logic                      ram_write_enable;
  logic                      ram_access_start;
  logic                      busy;
  logic                      done;
  logic                      error;
  logic [7:0]                error_count;

  modport master (
    output enable, data_in, sub_done, sub_addr, sub_data, sub_we, sub_as,
    input  sub_enable, sub_reset, ram_addr, ram_data_out, ram_write_enable,
           ram_access_start, busy, done, error, error_count
  );

  modport slave (
    input  enable, data_in, sub_done, sub_addr, sub_data, sub_we, sub_as,
    output sub_enable, sub_reset, ram_addr, ram_data_out, ram_write_enable,
           ram_access_start, busy, done, error, error_count
  );
endinterface

// File: rtl/control_cmd_dispatch.sv
// Opcode decoder and router: forwards payload bytes to the owning handler, muxes its RAM port,
// and aborts a handler that goes quiet for TIMEOUT_CYCLES.
//   state | meaning
//   IDLE  | waiting for an opcode byte
//   ROUTE | forwarding payload bytes to handler sel
//   ABORT | one cycle: reset the stalled handler, flag error
module control_cmd_dispatch #(
  parameter int                   NUM_SUB        = 4,
  parameter logic [NUM_SUB*8-1:0] OPCODE_TABLE   = {8'h43, 8'h46, 8'h50, 8'h4C},
  parameter int                   TIMEOUT_CYCLES = 4096,
  parameter int                   ADDR_W         = 16
) (
  input logic                   clk,
  input logic                   reset,
  control_cmd_dispatch_if.slave bus
);

  localparam int          SEL_W   = (NUM_SUB > 1) ? $clog2(NUM_SUB) : 1;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ROUTE, S_ABORT} state_t;

  state_t             state, state_n;
  logic [SEL_W-1:0]   sel;
  logic [15:0]        timer;
  logic [NUM_SUB-1:0] as_hist;
  logic               hit, accept, bad_op, sel_done;
  logic [SEL_W-1:0]   hit_idx;
  logic               busy_q, done_q, error_q, ras_q, we_q;
  logic [7:0]         err_cnt_q, data_q;
  logic [ADDR_W-1:0]  addr_q;

  assign sel_done = bus.sub_done[sel];
  assign bad_op   = accept && !hit;

  // descending scan so the lowest matching slice wins
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = NUM_SUB - 1; k >= 0; k--) begin
      if (bus.data_in == OPCODE_TABLE[8*k +: 8]) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      S_IDLE: accept = bus.enable;
      S_ROUTE: begin
        if (sel_done) begin
          state_n = S_IDLE;
          accept  = bus.enable;
        end else if (!bus.enable && timer == TO_LAST) begin
          state_n = S_ABORT;
        end
      end
      S_ABORT: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (accept && hit) state_n = S_ROUTE;
  end

  always_comb begin
    bus.sub_enable = '0;
    bus.sub_reset  = '0;
    if (state == S_ROUTE && bus.enable && !sel_done) bus.sub_enable[sel] = 1'b1;
    if (state == S_ABORT) bus.sub_reset[sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel       <= '0;
      timer     <= '0;
      as_hist   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_cnt_q <= '0;
      ras_q     <= 1'b0;
      we_q      <= 1'b0;
      data_q    <= '0;
      addr_q    <= '0;
    end else begin
      if (accept && hit) sel <= hit_idx;
      if (state != S_ROUTE || bus.enable) timer <= '0;
      else                                timer <= timer + 16'd1;
      busy_q  <= (state_n != S_IDLE);
      done_q  <= (state == S_ROUTE) && sel_done;
      error_q <= bad_op || (state_n == S_ABORT);
      if ((bad_op || state_n == S_ABORT) && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      as_hist <= bus.sub_as;
      // only the selected handler's toggle edges reach the shared strobe
      if (state == S_ROUTE && bus.sub_as[sel] != as_hist[sel]) ras_q <= ~ras_q;
      if (state == S_ROUTE) begin
        addr_q <= bus.sub_addr[int'(sel)*ADDR_W +: ADDR_W];
        data_q <= bus.sub_data[int'(sel)*8 +: 8];
        we_q   <= bus.sub_we[sel];
      end else begin
        addr_q <= '0;
        data_q <= '0;
        we_q   <= 1'b0;
      end
    end
  end

  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.error            = error_q;
  assign bus.error_count      = err_cnt_q;
  assign bus.ram_addr         = addr_q;
  assign bus.ram_data_out     = data_q;
  assign bus.ram_write_enable = we_q;
  assign bus.ram_access_start = ras_q;

endmodule

// File: tb/tb_control_cmd_dispatch.sv
// Bench for control_cmd_dispatch: directed scenarios plus random traffic, every cycle compared
// against a transaction-level model of the dispatcher.
module tb_control_cmd_dispatch;
  localparam int NS = 4;
  localparam int AW = 16;
  localparam int TO = 4096;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  control_cmd_dispatch_if #(.NUM_SUB(NS), .ADDR_W(AW)) bus ();
  control_cmd_dispatch #(.NUM_SUB(NS), .TIMEOUT_CYCLES(TO), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // handler k owns ops[k]
  logic [7:0] ops [NS] = '{8'h4C, 8'h50, 8'h46, 8'h43};

  function automatic int lookup(input logic [7:0] b);
    for (int k = 0; k < NS; k++) if (ops[k] == b) return k;
    return -1;
  endfunction

  // model: 0 waiting for opcode, 1 forwarding to owner, 2 aborting owner
  int          m_mode, m_owner, m_quiet, m_cnt, k_new;
  logic [NS-1:0] m_hist;
  logic        m_done, m_err, m_busy, m_we, m_ras, take_op;
  logic [AW-1:0] m_addr;
  logic [7:0]  m_data;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_owner = 0; m_quiet = 0; m_cnt = 0; m_hist = '0;
      m_done = 0; m_err = 0; m_busy = 0; m_we = 0; m_ras = 0; m_addr = '0; m_data = '0;
    end else begin
      m_done = 0; m_err = 0; take_op = 0;
      if (m_mode == 1) begin
        m_addr = bus.sub_addr[m_owner*AW +: AW];
        m_data = bus.sub_data[m_owner*8 +: 8];
        m_we   = bus.sub_we[m_owner];
        if (bus.sub_as[m_owner] != m_hist[m_owner]) m_ras = ~m_ras;
      end else begin
        m_addr = '0; m_data = '0; m_we = 0;
      end
      m_hist = bus.sub_as;
      case (m_mode)
        0: take_op = bus.enable;
        1: begin
          if (bus.sub_done[m_owner]) begin
            m_done = 1; m_mode = 0; take_op = bus.enable;
          end else if (bus.enable) begin
            m_quiet = 0;
          end else begin
            m_quiet++;
            if (m_quiet == TO) begin m_mode = 2; m_err = 1; end
          end
        end
        default: m_mode = 0;
      endcase
      if (take_op) begin
        k_new = lookup(bus.data_in);
        if (k_new < 0) m_err = 1;
        else begin m_mode = 1; m_owner = k_new; m_quiet = 0; end
      end
      if (m_err && m_cnt < 255) m_cnt++;
      m_busy = (m_mode != 0);
    end
  end

  int en_cnt [NS];
  int rst_cnt [NS];
  int done_cnt, err_pulses, ras_flips;
  logic ras_prev = 0;
  logic [NS-1:0] exp_en, exp_rst;

  always @(negedge clk) begin
    exp_en  = '0;
    exp_rst = '0;
    if (m_mode == 1 && bus.enable && !bus.sub_done[m_owner]) exp_en[m_owner] = 1'b1;
    if (m_mode == 2) exp_rst[m_owner] = 1'b1;
    check("sub_enable", 32'(bus.sub_enable), 32'(exp_en));
    check("sub_reset", 32'(bus.sub_reset), 32'(exp_rst));
    check("busy", 32'(bus.busy), 32'(m_busy));
    check("done", 32'(bus.done), 32'(m_done));
    check("error", 32'(bus.error), 32'(m_err));
    check("error_count", 32'(bus.error_count), 32'(m_cnt));
    check("ram_addr", 32'(bus.ram_addr), 32'(m_addr));
    check("ram_data_out", 32'(bus.ram_data_out), 32'(m_data));
    check("ram_write_enable", 32'(bus.ram_write_enable), 32'(m_we));
    check("ram_access_start", 32'(bus.ram_access_start), 32'(m_ras));
    for (int k = 0; k < NS; k++) begin
      if (bus.sub_enable[k] === 1'b1) en_cnt[k]++;
      if (bus.sub_reset[k] === 1'b1) rst_cnt[k]++;
    end
    if (bus.done === 1'b1) done_cnt++;
    if (bus.error === 1'b1) err_pulses++;
    if (bus.ram_access_start !== ras_prev) ras_flips++;
    ras_prev = bus.ram_access_start;
  end

  task automatic clear_counts();
    for (int k = 0; k < NS; k++) begin en_cnt[k] = 0; rst_cnt[k] = 0; end
    done_cnt = 0; err_pulses = 0; ras_flips = 0;
  endtask

  logic rnd_bus = 0;

  task automatic step(input logic en, input logic [7:0] d, input logic [NS-1:0] dn);
    bus.enable = en; bus.data_in = d; bus.sub_done = dn;
    if (rnd_bus) begin
      for (int k = 0; k < NS; k++) begin
        bus.sub_addr[k*AW +: AW] = AW'($urandom);
        bus.sub_data[k*8 +: 8]   = 8'($urandom);
        bus.sub_we[k]            = 1'($urandom);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bus.enable = 0; bus.data_in = '0; bus.sub_done = '0; bus.sub_addr = '0;
    bus.sub_data = '0; bus.sub_we = '0; bus.sub_as = '0;
    clear_counts();
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset error_count", 32'(bus.error_count), 32'd0);

    // opcode 4C + four payload bytes, completion one cycle after the last byte
    clear_counts();
    step(1, 8'h4C, '0);
    for (int i = 0; i < 4; i++) step(1, 8'(8'h10 + i), '0);
    step(0, 8'h00, 4'b0001);
    step(0, 8'h00, '0);
    check("t1 handler0 bytes", 32'(en_cnt[0]), 32'd4);
    check("t1 other bytes", 32'(en_cnt[1] + en_cnt[2] + en_cnt[3]), 32'd0);
    check("t1 done pulses", 32'(done_cnt), 32'd1);
    check("t1 busy after", 32'(bus.busy), 32'd0);

    // unknown opcode
    clear_counts();
    step(1, 8'hFF, '0);
    check("t2 error now", 32'(bus.error), 32'd1);
    step(0, 8'h00, '0);
    check("t2 error_count", 32'(bus.error_count), 32'd1);
    check("t2 error pulses", 32'(err_pulses), 32'd1);
    check("t2 busy", 32'(bus.busy), 32'd0);
    check("t2 no bytes", 32'(en_cnt[0] + en_cnt[1] + en_cnt[2] + en_cnt[3]), 32'd0);

    // access-start toggles: handler 0 three times, handler 2 every cycle
    rnd_bus = 1;
    step(1, 8'h4C, '0);
    clear_counts();
    for (int i = 0; i < 8; i++) begin
      if (i == 1 || i == 3 || i == 5) bus.sub_as[0] = ~bus.sub_as[0];
      bus.sub_as[2] = ~bus.sub_as[2];
      step(1'(i % 2), 8'h20, '0);
    end
    step(0, 8'h00, 4'b0001);
    step(0, 8'h00, '0);
    check("t3 access toggles", 32'(ras_flips), 32'd3);
    rnd_bus = 0;

    // stall after opcode 50 -> handler 1 aborted
    clear_counts();
    step(1, 8'h50, '0);
    repeat (TO + 3) step(0, 8'h00, '0);
    check("t4 sub_reset[1]", 32'(rst_cnt[1]), 32'd1);
    check("t4 other resets", 32'(rst_cnt[0] + rst_cnt[2] + rst_cnt[3]), 32'd0);
    check("t4 error pulses", 32'(err_pulses), 32'd1);
    check("t4 error_count", 32'(bus.error_count), 32'd2);
    check("t4 busy", 32'(bus.busy), 32'd0);
    step(1, 8'h4C, '0);
    check("t4 redecode busy", 32'(bus.busy), 32'd1);
    step(0, 8'h00, 4'b0001);
    step(0, 8'h00, '0);

    // back-to-back: completion coincides with opcode 46 (handler 2)
    step(1, 8'h4C, '0);
    step(1, 8'h11, '0);
    clear_counts();
    step(1, 8'h46, 4'b0001);
    step(1, 8'h22, '0);
    check("t5 done pulses", 32'(done_cnt), 32'd1);
    check("t5 handler2 bytes", 32'(en_cnt[2]), 32'd1);
    check("t5 handler0 bytes", 32'(en_cnt[0]), 32'd0);
    check("t5 busy", 32'(bus.busy), 32'd1);
    step(0, 8'h00, 4'b0100);
    step(0, 8'h00, '0);

    // reset mid-command
    step(1, 8'h4C, '0);
    step(1, 8'h33, '0);
    #2 reset = 1;
    #1;
    check("t6 busy in reset", 32'(bus.busy), 32'd0);
    check("t6 sub_enable in reset", 32'(bus.sub_enable), 32'd0);
    check("t6 error_count in reset", 32'(bus.error_count), 32'd0);
    bus.enable = 0;
    #3 reset = 0;
    @(posedge clk); #1;
    step(1, 8'h4C, '0);
    check("t6 first byte is opcode", 32'(bus.busy), 32'd1);
    step(0, 8'h00, 4'b0001);
    step(0, 8'h00, '0);

    // random traffic
    rnd_bus = 1;
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] d;
      logic [NS-1:0] dn;
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ops[$urandom_range(0, NS - 1)];
      for (int k = 0; k < NS; k++) dn[k] = ($urandom_range(0, 9) == 0);
      bus.sub_as = bus.sub_as ^ NS'($urandom);
      step(($urandom_range(0, 2) == 0), d, dn);
    end
    step(0, 8'h00, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
